// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Requester IDs identify the writeback sources competing for the single RF write port.
package rf_wb_arbiter_pkg;

   localparam int NUM_REQ   = 3;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int NUM_REGS  = 1 << ADDR_W;
   localparam int REQ_IDX_W = 2;

   localparam logic [REQ_IDX_W-1:0] REQ_ALU    = 2'd0;
   localparam logic [REQ_IDX_W-1:0] REQ_LOAD   = 2'd1;
   localparam logic [REQ_IDX_W-1:0] REQ_MULDIV = 2'd2;

   // Successor of a requester index in round-robin order (wraps after the last requester).
   function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] i);
      return (i == REQ_MULDIV) ? REQ_ALU : i + 2'd1;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Three-way round-robin selector: ptr names the requester with highest priority,
// the grant is one-hot on the first active request found from ptr onwards, or zero.
module rr_arbiter3
   import rf_wb_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0]   req,
   input  logic [REQ_IDX_W-1:0] ptr,
   output logic [NUM_REQ-1:0]   grant
);

   logic [REQ_IDX_W-1:0] idx;
   logic                 found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
         idx = rr_next(idx);
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register-file write port, with an issue-time busy scoreboard
// that flags source operands whose producer has not written back yet.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
(
   input  logic                              RF_clk,
   input  logic                              RF_rst,
   input  logic [NUM_REQ-1:0]                wb_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]    wb_rdc,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]    wb_data,
   output logic [NUM_REQ-1:0]                wb_ready,
   input  logic                              iss_valid,
   input  logic [ADDR_W-1:0]                 iss_rdc,
   input  logic [ADDR_W-1:0]                 iss_rsc,
   input  logic [ADDR_W-1:0]                 iss_rtc,
   output logic                              iss_stall,
   input  logic                              sb_flush,
   output logic                              RF_ena,
   output logic                              RF_W,
   output logic [ADDR_W-1:0]                 Rdc,
   output logic [DATA_W-1:0]                 Rd
);

   // Handshake: wb_valid[i] && wb_ready[i] at posedge RF_clk; a requester holds
   // wb_rdc/wb_data stable until then. wb_ready depends only on wb_valid and ptr_q.

   logic [REQ_IDX_W-1:0] ptr_q,  ptr_d;
   logic                 rf_w_q, rf_w_d;
   logic [ADDR_W-1:0]    rdc_q,  rdc_d;
   logic [DATA_W-1:0]    rd_q,   rd_d;
   logic [NUM_REGS-1:0]  busy_q, busy_d;

   logic [NUM_REQ-1:0]   grant;
   logic                 hs;
   logic [REQ_IDX_W-1:0] sel_idx;
   logic [ADDR_W-1:0]    sel_rdc;
   logic [DATA_W-1:0]    sel_data;

   rr_arbiter3 u_rr (
      .req   (wb_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   assign wb_ready  = RF_rst ? '0 : grant;
   assign iss_stall = busy_q[iss_rsc] | busy_q[iss_rtc];
   assign RF_ena    = ~RF_rst;
   assign RF_W      = rf_w_q;
   assign Rdc       = rdc_q;
   assign Rd        = rd_q;

   always_comb begin
      hs       = |wb_ready;
      sel_idx  = '0;
      sel_rdc  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wb_ready[i]) begin
            sel_idx  = REQ_IDX_W'(i);
            sel_rdc  = wb_rdc[i];
            sel_data = wb_data[i];
         end
      end

      ptr_d  = hs ? rr_next(sel_idx) : ptr_q;
      // Writes to r0 are accepted but never reach the register file.
      rf_w_d = hs && (sel_rdc != '0);
      rdc_d  = hs ? sel_rdc  : rdc_q;
      rd_d   = hs ? sel_data : rd_q;

      // Priority low to high: writeback clear, issue set, flush.
      busy_d = busy_q;
      if (hs)
         busy_d[sel_rdc] = 1'b0;
      if (iss_valid)
         busy_d[iss_rdc] = 1'b1;
      if (sb_flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge RF_clk or posedge RF_rst) begin
      if (RF_rst) begin
         ptr_q  <= REQ_ALU;
         rf_w_q <= 1'b0;
         rdc_q  <= '0;
         rd_q   <= '0;
         busy_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         rf_w_q <= rf_w_d;
         rdc_q  <= rdc_d;
         rd_q   <= rd_d;
         busy_q <= busy_d;
      end
   end

endmodule
